// File: rtl/enc4to2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : enc4to2_stream
//  Description : Streams the binary index of every set bit of a 4-bit request
//                vector, lowest first, over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module enc4to2_stream #(
    parameter int N_IN  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_code,
    output logic             out_last,
    output logic             multi_hot,
    output logic             zero_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [0:0]       c_IDLE     = 1'b0;
    localparam logic [0:0]       c_EMIT     = 1'b1;
    localparam logic [N_IN-1:0]  c_VEC_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [N_IN-1:0]  r_pending;
    logic             r_multi_hot;
    logic             r_zero_err;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_accept;
    logic             w_xfer;
    logic             w_vec_zero;
    logic             w_vec_multi;
    logic             w_pend_single;
    logic [1:0]       w_low_idx;

    assign w_accept      = in_valid && in_ready;
    assign w_xfer        = out_valid && out_ready;
    assign w_vec_zero    = (in_vec == '0);
    // x & (x-1) clears the lowest set bit; non-zero result means >1 bit set
    assign w_vec_multi   = |(in_vec & (in_vec - c_VEC_ONE));
    assign w_pend_single = (r_pending != '0) &&
                           ((r_pending & (r_pending - c_VEC_ONE)) == '0);

    always_comb begin
        w_low_idx = 2'd0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_idx = i[1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept && !w_vec_zero) begin
                    w_state_nxt = c_EMIT;
                end
            end
            c_EMIT: begin
                if (w_xfer && w_pend_single) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // in_ready is gated by rst so nothing is offered while reset is held
    always_comb begin
        in_ready  = (r_state == c_IDLE) && !rst;
        out_valid = (r_state == c_EMIT);
        out_code  = out_valid ? w_low_idx : 2'd0;
        out_last  = out_valid && w_pend_single;
        multi_hot = r_multi_hot;
        zero_err  = r_zero_err;
        err_cnt   = r_err_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending   <= '0;
            r_multi_hot <= 1'b0;
            r_zero_err  <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_zero_err <= 1'b0;
            if (w_accept) begin
                if (w_vec_zero) begin
                    r_zero_err <= 1'b1;
                    if (r_err_cnt != c_CNT_MAX) begin
                        r_err_cnt <= r_err_cnt + c_CNT_ONE;
                    end
                end else begin
                    r_pending   <= in_vec;
                    r_multi_hot <= w_vec_multi;
                end
            end else if (w_xfer) begin
                r_pending <= r_pending & (r_pending - c_VEC_ONE);
                if (w_pend_single) begin
                    r_multi_hot <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_enc4to2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enc4to2_stream
//  Description : Self-checking bench for enc4to2_stream with a queue-based
//                reference of the expected code stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enc4to2_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [3:0] in_vec;
    logic [1:0] out_code;
    logic       out_last, multi_hot, zero_err;
    logic [7:0] err_cnt;

    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [3:0] s_in_vec;
    logic [1:0] s_out_code;
    logic       s_out_last, s_multi_hot, s_zero_err;
    logic [1:0] s_err_cnt;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    enc4to2_stream #(.N_IN(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_last(out_last), .multi_hot(multi_hot), .zero_err(zero_err),
        .err_cnt(err_cnt)
    );

    enc4to2_stream #(.N_IN(4), .CNT_W(2)) u_dut_small (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_vec(s_in_vec),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_code(s_out_code),
        .out_last(s_out_last), .multi_hot(s_multi_hot), .zero_err(s_zero_err),
        .err_cnt(s_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    // Expected stream: indices of set bits, ascending; length = popcount
    task automatic send_vec(input logic [3:0] vec, input int stall_first, input bit rand_ready);
        logic [1:0] q[$];
        logic [3:0] dec;
        int         cnt;
        int         guard;
        bit         rdy;
        bit         exp_multi;
        for (int i = 0; i < 4; i++) begin
            if (vec[i]) q.push_back(i[1:0]);
        end
        exp_multi = ($countones(vec) > 1);
        wait_ready();
        in_valid  = 1'b1;
        in_vec    = vec;
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        in_valid = 1'b0;
        in_vec   = 4'($urandom);
        if (vec == 4'd0) begin
            if (exp_err < 255) exp_err++;
            check("zero_err_pulse", {31'd0, zero_err}, 32'd1);
            check("zero_no_valid", {31'd0, out_valid}, 32'd0);
            check("err_cnt", {24'd0, err_cnt}, exp_err);
            @(negedge clk);
            check("zero_err_clear", {31'd0, zero_err}, 32'd0);
            check("zero_in_ready", {31'd0, in_ready}, 32'd1);
            return;
        end
        dec   = 4'd0;
        cnt   = 0;
        guard = 0;
        while (q.size() > 0 && guard < 100) begin
            check("out_valid", {31'd0, out_valid}, 32'd1);
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            check("out_code", {30'd0, out_code}, {30'd0, q[0]});
            check("out_last", {31'd0, out_last}, (q.size() == 1) ? 32'd1 : 32'd0);
            check("multi_hot", {31'd0, multi_hot}, {31'd0, exp_multi});
            if (guard < stall_first) rdy = 1'b0;
            else if (rand_ready)     rdy = ($urandom_range(0, 2) != 0);
            else                     rdy = 1'b1;
            out_ready = rdy;
            in_valid  = 1'($urandom_range(0, 1));
            in_vec    = 4'($urandom);
            if (rdy) begin
                dec = dec | (4'b0001 << out_code);
                cnt++;
                void'(q.pop_front());
            end
            guard++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("burst_done", q.size(), 32'd0);
        check("idle_valid", {31'd0, out_valid}, 32'd0);
        check("idle_ready", {31'd0, in_ready}, 32'd1);
        check("idle_multi", {31'd0, multi_hot}, 32'd0);
        check("roundtrip_or", {28'd0, dec}, {28'd0, vec});
        check("roundtrip_len", cnt, $countones(vec));
    endtask

    initial begin
        logic [3:0] v;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_vec      = 4'd0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_vec    = 4'd0;
        s_out_ready = 1'b1;
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_code", {30'd0, out_code}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_multi_hot", {31'd0, multi_hot}, 32'd0);
        check("rst_zero_err", {31'd0, zero_err}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            v = 4'b0001 << i;
            send_vec(v, 0, 1'b0);
        end
        send_vec(4'b1011, 0, 1'b0);
        send_vec(4'b1111, 3, 1'b0);
        for (int i = 0; i < 3; i++) send_vec(4'b0000, 0, 1'b0);
        check("err_cnt_three", {24'd0, err_cnt}, 32'd3);

        s_in_valid = 1'b1;
        s_in_vec   = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("small_err_cnt", {30'd0, s_err_cnt}, (k < 3) ? k : 3);
            check("small_zero_err", {31'd0, s_zero_err}, 32'd1);
            check("small_no_valid", {31'd0, s_out_valid}, 32'd0);
        end
        s_in_valid = 1'b0;
        @(negedge clk);
        check("small_zero_clear", {31'd0, s_zero_err}, 32'd0);

        wait_ready();
        in_valid  = 1'b1;
        in_vec    = 4'b0110;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_code0", {30'd0, out_code}, 32'd1);
        check("mid_multi", {31'd0, multi_hot}, 32'd1);
        @(negedge clk);
        check("mid_code1", {30'd0, out_code}, 32'd2);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_last", {31'd0, out_last}, 32'd0);
        exp_err = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rel_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rel_err_cnt", {24'd0, err_cnt}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("mid_no_resume", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end

        for (int i = 1; i < 16; i++) begin
            v = 4'(i);
            send_vec(v, 0, 1'b1);
        end
        for (int i = 0; i < 30; i++) begin
            v = 4'($urandom_range(0, 15));
            send_vec(v, $urandom_range(0, 2), 1'b1);
        end
        check("final_err_cnt", {24'd0, err_cnt}, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
